adder_pipe_transport: RTL and testbench

- Clocked 4-bit adder with carry-in whose results leave LATENCY cycles after they are accepted.
- This is the transport-delay counterpart of our inertial-delay continuous-assign adder models: every accepted operand set produces exactly one result, in order, and nothing is swallowed.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

---
 rtl/adder_pipe_pkg.sv | 16 +
 rtl/adder_pipe_stage.sv | 33 +++
 rtl/adder_pipe_transport.sv | 90 +++++++++
 tb/tb_adder_pipe_transport.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared result type and limits for the transport-delay adder pipeline.
// ADDER_PIPE_OVF_EN adds a signed-overflow bit to the result payload.
package adder_pipe_pkg;

   localparam int MAX_LATENCY = 8;
   localparam int RES_WIDTH   = 4;

   typedef struct packed {
`ifdef ADDER_PIPE_OVF_EN
      logic                 ovf;
`endif
      logic                 co;
      logic [RES_WIDTH-1:0] sum;
   } adder_res_t;

endpackage

// File: rtl/adder_pipe_stage.sv
// One valid+payload pipeline register; payload only moves with valid data,
// so an emptied stage keeps its last result on the outputs.
module adder_pipe_stage
   import adder_pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic       i_valid,
   input  adder_res_t i_d,
   output logic       o_valid,
   output adder_res_t o_q
);

   logic       r_valid;
   adder_res_t r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_q     <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_q <= i_d;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_q     = r_q;

endmodule

// File: rtl/adder_pipe_transport.sv
// Clocked adder with carry-in, LATENCY-deep bubble-collapsing valid/ready pipe.
// Optional ovf output when ADDER_PIPE_OVF_EN is defined.
module adder_pipe_transport
   import adder_pipe_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co,
`ifdef ADDER_PIPE_OVF_EN
   output logic             ovf,
`endif
   output logic             out_valid,
   input  logic             out_ready
);

   if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $fatal(1, "adder_pipe_transport: LATENCY must be 1..%0d", MAX_LATENCY);
   end
   if (WIDTH != RES_WIDTH) begin : g_bad_width
      $fatal(1, "adder_pipe_transport: WIDTH must equal %0d", RES_WIDTH);
   end

   logic [WIDTH:0]     w_add;
   adder_res_t         w_res;
   logic [LATENCY-1:0] w_v;
   logic [LATENCY-1:0] w_adv;
   adder_res_t         w_q [LATENCY];

   assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

   always_comb begin
      w_res     = '0;
      w_res.co  = w_add[WIDTH];
      w_res.sum = w_add[WIDTH-1:0];
`ifdef ADDER_PIPE_OVF_EN
      w_res.ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                  (w_add[WIDTH-1] != a[WIDTH-1]);
`endif
   end

   // A stage advances when empty or when its successor takes its result.
   always_comb begin
      w_adv = '0;
      w_adv[LATENCY-1] = !w_v[LATENCY-1] || out_ready;
      for (int k = LATENCY - 2; k >= 0; k--) begin
         w_adv[k] = !w_v[k] || w_adv[k+1];
      end
   end

   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      logic       w_in_v;
      adder_res_t w_in_d;

      if (k == 0) begin : g_first
         assign w_in_v = in_valid;
         assign w_in_d = w_res;
      end else begin : g_next
         assign w_in_v = w_v[k-1];
         assign w_in_d = w_q[k-1];
      end

      adder_pipe_stage u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_load  (w_adv[k]),
         .i_valid (w_in_v),
         .i_d     (w_in_d),
         .o_valid (w_v[k]),
         .o_q     (w_q[k])
      );
   end

   assign in_ready  = w_adv[0];
   assign out_valid = w_v[LATENCY-1];
   assign sum       = w_q[LATENCY-1].sum;
   assign co        = w_q[LATENCY-1].co;
`ifdef ADDER_PIPE_OVF_EN
   assign ovf       = w_q[LATENCY-1].ovf;
`endif

endmodule

// File: tb/tb_adder_pipe_transport.sv
// Scoreboard bench for adder_pipe_transport: directed vectors, burst,
// backpressure, bubbles, mid-flight reset.
module tb_adder_pipe_transport;

   localparam int W = 4;
   localparam int L = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         ci = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] sum;
   logic         co;
   logic         out_valid;
   logic         out_ready = 1'b1;
`ifdef ADDER_PIPE_OVF_EN
   logic         ovf;
`endif

   adder_pipe_transport #(.WIDTH(W), .LATENCY(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sum       (sum),
      .co        (co),
`ifdef ADDER_PIPE_OVF_EN
      .ovf       (ovf),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] cs;
      logic       ov;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   n_chk = 0;
   int   n_err = 0;

   function automatic void chk(string nm, logic [7:0] got, logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endfunction

   function automatic logic ovf_of(logic [3:0] x, logic [3:0] y, logic c);
      logic [3:0] s;
      s = x + y + {3'b0, c};
      return (x[3] == y[3]) && (s[3] != x[3]);
   endfunction

   function automatic void push(logic [3:0] x, logic [3:0] y, logic c,
                                logic [4:0] e);
      exp_t t;
      t.cs = e;
      t.ov = ovf_of(x, y, c);
      q.push_back(t);
   endfunction

   // Monitor: a result transfers on the next edge when valid && ready.
   initial forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("stale", 8'(1), 8'(0));
         end else begin
            m_e = q.pop_front();
            chk("res", 8'({co, sum}), 8'(m_e.cs));
`ifdef ADDER_PIPE_OVF_EN
            chk("ovf", 8'(ovf), 8'(m_e.ov));
`endif
         end
      end
   end

   task automatic send(input logic [3:0] ta, input logic [3:0] tb,
                       input logic tc, input logic [4:0] e);
      int n = 0;
      @(posedge clk); #1;
      a = ta; b = tb; ci = tc; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) chk("send_timeout", 8'(0), 8'(1));
      else push(ta, tb, tc, e);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
      chk("drain", 8'(q.size() == 0), 8'(1));
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         cnt;
      int         ops;
      logic       tog;
      logic [4:0] hs;
      logic [3:0] bv;

      #12;
      chk("rst_valid", 8'(out_valid), 8'(0));
      chk("rst_sum", 8'(sum), 8'(0));
      chk("rst_co", 8'(co), 8'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 8'(in_ready), 8'(1));

      // Single op latency: visible LATENCY-1 cycles after accept, one cycle.
      @(posedge clk); #1;
      a = 4'd3; b = 4'd4; ci = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      chk("lat_ready", 8'(in_ready), 8'(1));
      push(4'd3, 4'd4, 1'b1, 5'h08);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int j = 1; j <= L + 1; j++) begin
         @(negedge clk);
         chk("lat_valid", 8'(out_valid), 8'(j == L));
      end
      wait_drain();

      send(4'hF, 4'hF, 1'b1, 5'h1F);
      send(4'hF, 4'h0, 1'b1, 5'h10);
      send(4'h7, 4'h1, 1'b0, 5'h08);
      send(4'h8, 4'h8, 1'b0, 5'h10);
      wait_drain();

      // Burst: 16 back-to-back ops, in_ready must stay high.
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) begin
         a = 4'(i); b = 4'(i); ci = i[0]; in_valid = 1'b1;
         @(negedge clk);
         chk("burst_ready", 8'(in_ready), 8'(1));
         if (in_ready) push(4'(i), 4'(i), i[0], 5'(2 * i + i % 2));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain();

      // Backpressure: fill, hold, then release.
      @(posedge clk); #1;
      out_ready = 1'b0;
      cnt = 0;
      for (int k = 0; k < L + 3; k++) begin
         a = 4'(k + 5); b = 4'(2 * k); ci = k[0]; in_valid = 1'b1;
         @(negedge clk);
         if (!in_ready) break;
         push(4'(k + 5), 4'(2 * k), k[0], 5'(3 * k + 5 + k % 2));
         cnt++;
         @(posedge clk); #1;
      end
      chk("bp_accepts", 8'(cnt), 8'(L));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      hs = {co, sum};
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_hold", 8'({co, sum}), 8'(hs));
         chk("bp_full", 8'(in_ready), 8'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_rise", 8'(in_ready), 8'(1));
      wait_drain();

      // Bubbles with random output stalls.
      ops = 0;
      tog = 1'b0;
      for (int c = 0; c < 3000 && ops < 200; c++) begin
         @(posedge clk); #1;
         out_ready = 1'($urandom_range(0, 1));
         tog = !tog;
         bv = 4'(ops * 7);
         a = 4'(ops); b = bv; ci = ops[1]; in_valid = tog;
         @(negedge clk);
         if (in_valid && in_ready) begin
            push(4'(ops), bv, ops[1], 5'(ops % 16 + bv + ops[1]));
            ops++;
         end
      end
      chk("bub_ops", 8'(ops), 8'(200));
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();

      // Reset with two results in flight.
      @(posedge clk); #1;
      a = 4'd9; b = 4'd9; ci = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 4'd2; b = 4'd5; ci = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 8'(out_valid), 8'(0));
      chk("mrst_sum", 8'(sum), 8'(0));
      chk("mrst_co", 8'(co), 8'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_ready", 8'(in_ready), 8'(1));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("mrst_empty", 8'(out_valid), 8'(0));
      end

      send(4'h7, 4'h1, 1'b0, 5'h08);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
